// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH -> DECODE -> EXECUTE -> WRITEBACK sequencer for the RV32I ALU datapath.
// Define PERF_COUNTERS_EN to expose the retired_count and stall_count ports.
module multicycle_controller #(
  parameter int MAX_RETIRE   = 0,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [31:0]             instruction,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    reg_write_enable,
  output logic [2:0]              alu_op,
  output logic                    use_imm,
  output logic [2:0]              state_out,
  output logic                    halted,
  output logic                    trap
`ifdef PERF_COUNTERS_EN
  ,
  output logic [RETIRE_CNT_W-1:0] retired_count,
  output logic [31:0]             stall_count
`endif
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;
  localparam logic [2:0] ST_TRAP      = 3'd5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [RETIRE_CNT_W-1:0] CNT_ONE   = RETIRE_CNT_W'(1);
  localparam logic [RETIRE_CNT_W-1:0] CNT_LIMIT = RETIRE_CNT_W'(MAX_RETIRE);

  logic [2:0]  state;
  logic [31:0] ir;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        dec_legal;
  logic [2:0]  dec_op;
  logic        dec_imm;
  logic        retire_limit;

  assign f7 = ir[31:25];
  assign f3 = ir[14:12];

  // NOTE: every variable gets a default first so no path through the case statements infers a latch.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_imm   = 1'b0;
    case (f3)
      3'b000:  begin dec_legal = 1'b1;           dec_op = ALU_ADD; end
      3'b010:  begin dec_legal = 1'b1;           dec_op = ALU_SLT; end
      3'b100:  begin dec_legal = 1'b1;           dec_op = ALU_XOR; end
      3'b110:  begin dec_legal = 1'b1;           dec_op = ALU_OR;  end
      3'b111:  begin dec_legal = 1'b1;           dec_op = ALU_AND; end
      3'b001:  begin dec_legal = (f7 == 7'd0);   dec_op = ALU_SLL; end
      3'b101:  begin dec_legal = (f7 == 7'd0);   dec_op = ALU_SRL; end
      default: dec_legal = 1'b0;
    endcase
    case (ir[6:0])
      OPC_R: begin
        // f3=000 is the only R-type slot where f7 selects between two operations.
        if (f3 == 3'b000) begin
          dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          dec_op    = (f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        end
      end
      OPC_I:   dec_imm   = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      ir      <= '0;
      alu_op  <= ALU_ADD;
      use_imm <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run) begin
            ir    <= instruction;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (ir == 32'd0) begin
            state <= ST_HALT;
          end else if (dec_legal) begin
            alu_op  <= dec_op;
            use_imm <= dec_imm;
            state   <= ST_EXECUTE;
          end else begin
            state <= ST_TRAP;
          end
        end
        ST_EXECUTE:   state <= ST_WRITEBACK;
        ST_WRITEBACK: state <= retire_limit ? ST_HALT : ST_FETCH;
        default:      state <= state;
      endcase
    end
  end

  // NOTE: strobes are gated by reset so an instruction abandoned by reset never writes.
  assign ir_write         = !reset && (state == ST_FETCH) && run;
  assign pc_write         = !reset && (state == ST_WRITEBACK);
  assign reg_write_enable = pc_write;
  assign state_out        = state;
  assign halted           = (state == ST_HALT);
  assign trap             = (state == ST_TRAP);

`ifdef PERF_COUNTERS_EN
  logic [RETIRE_CNT_W-1:0] retire_cnt;
  logic [31:0]             stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (pc_write) retire_cnt <= retire_cnt + CNT_ONE;
      if ((state == ST_FETCH) && !run) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign retire_limit  = (MAX_RETIRE != 0) && (retire_cnt + CNT_ONE == CNT_LIMIT);
  assign retired_count = retire_cnt;
  assign stall_count   = stall_cnt;
`else
  generate
    if (MAX_RETIRE != 0) begin : g_retire
      logic [RETIRE_CNT_W-1:0] retire_cnt;

      always_ff @(posedge clk) begin
        if (reset)         retire_cnt <= '0;
        else if (pc_write) retire_cnt <= retire_cnt + CNT_ONE;
      end

      assign retire_limit = (retire_cnt + CNT_ONE == CNT_LIMIT);
    end else begin : g_no_retire
      assign retire_limit = 1'b0;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an unlimited instance plus a MAX_RETIRE=2 instance.
// Build with PERF_COUNTERS_EN defined to also check the performance counters.
module tb_multicycle_controller;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3, ST_HALT = 3'd4, ST_TRAP = 3'd5;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_SLT = 3'd7;

  localparam logic [31:0] ADD_W   = 32'h005303b3;
  localparam logic [31:0] SUB_W   = 32'h40848533;
  localparam logic [31:0] ADDI_W  = 32'h00160693;
  localparam logic [31:0] JAL_W   = 32'h0000006f;
  localparam logic [31:0] SRLBAD_W = 32'h4062d3b3;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instruction;

  logic       ir_write, pc_write, reg_write_enable, use_imm, halted, trap;
  logic [2:0] alu_op, state_out;
  logic       lim_ir_write, lim_pc_write, lim_rwe, lim_use_imm, lim_halted, lim_trap;
  logic [2:0] lim_alu_op, lim_state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] retired_count, stall_count, lim_retired_count, lim_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write_enable(reg_write_enable),
    .alu_op(alu_op), .use_imm(use_imm), .state_out(state_out),
    .halted(halted), .trap(trap)
`ifdef PERF_COUNTERS_EN
    , .retired_count(retired_count), .stall_count(stall_count)
`endif
  );

  multicycle_controller #(.MAX_RETIRE(2), .RETIRE_CNT_W(32)) dut_lim (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .ir_write(lim_ir_write), .pc_write(lim_pc_write), .reg_write_enable(lim_rwe),
    .alu_op(lim_alu_op), .use_imm(lim_use_imm), .state_out(lim_state),
    .halted(lim_halted), .trap(lim_trap)
`ifdef PERF_COUNTERS_EN
    , .retired_count(lim_retired_count), .stall_count(lim_stall_count)
`endif
  );

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd5, 5'd6, f3, 5'd7, opc};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Leaves the bench one step after the last reset edge: cycle 1 of the program, state FETCH.
  task automatic apply_reset(input logic [31:0] word, input logic run_val);
    reset = 1'b1;
    run = run_val;
    instruction = word;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b1;
    instruction = ADD_W;
    next_cycle();
    next_cycle();
    mid();
    checks++; if (state_out !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_out, ST_FETCH); end
    checks++; if ({ir_write, pc_write, reg_write_enable} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {ir_write, pc_write, reg_write_enable}); end
    checks++; if ({alu_op, use_imm} !== {ALU_ADD, 1'b0}) begin errors++; $display("FAIL reset_alu: got %b expected %b", {alu_op, use_imm}, {ALU_ADD, 1'b0}); end
    checks++; if ({halted, trap} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {halted, trap}); end
`ifdef PERF_COUNTERS_EN
    checks++; if (retired_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", retired_count, stall_count); end
`endif
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_add();
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++; if (state_out !== 3'(c)) begin errors++; $display("FAIL add_state c%0d: got %0d expected %0d", c, state_out, c); end
      checks++; if (ir_write !== (c == 0)) begin errors++; $display("FAIL add_ir_write c%0d: got %b expected %b", c, ir_write, (c == 0)); end
      checks++; if (reg_write_enable !== (c == 3) || pc_write !== (c == 3)) begin errors++; $display("FAIL add_wb_strobes c%0d: got %b%b expected %b%b", c, reg_write_enable, pc_write, (c == 3), (c == 3)); end
      if (c >= 2) begin
        checks++; if ({alu_op, use_imm} !== {ALU_ADD, 1'b0}) begin errors++; $display("FAIL add_alu c%0d: got %b expected %b", c, {alu_op, use_imm}, {ALU_ADD, 1'b0}); end
      end
      next_cycle();
    end
  endtask

  task automatic test_sub_addi();
    logic [31:0] words [2];
    logic [2:0]  ops [2];
    logic        imms [2];
    int          cyc, wb [2];
    words[0] = SUB_W;  ops[0] = ALU_SUB; imms[0] = 1'b0;
    words[1] = ADDI_W; ops[1] = ALU_ADD; imms[1] = 1'b1;
    cyc = 0;
    wb[0] = -1; wb[1] = -1;
    for (int k = 0; k < 2; k++) begin
      instruction = words[k];
      for (int c = 0; c < 4; c++) begin
        mid();
        if (reg_write_enable === 1'b1) wb[k] = cyc;
        checks++; if (state_out !== 3'(c)) begin errors++; $display("FAIL b2b_state i%0d c%0d: got %0d expected %0d", k, c, state_out, c); end
        if (c >= 2) begin
          checks++; if ({alu_op, use_imm} !== {ops[k], imms[k]}) begin errors++; $display("FAIL b2b_alu i%0d c%0d: got %b expected %b", k, c, {alu_op, use_imm}, {ops[k], imms[k]}); end
        end
        next_cycle();
        cyc++;
      end
    end
    checks++; if (wb[0] !== 3 || wb[1] !== 7) begin errors++; $display("FAIL b2b_wb_cycles: got %0d,%0d expected 3,7", wb[0], wb[1]); end
    mid();
    checks++; if ({alu_op, use_imm} !== {ALU_ADD, 1'b1}) begin errors++; $display("FAIL b2b_alu_hold: got %b expected %b", {alu_op, use_imm}, {ALU_ADD, 1'b1}); end
  endtask

  task automatic test_decode();
    logic [31:0] words [18];
    logic [3:0]  exp [18];
    // exp = {legal, alu_op}; use_imm is 1 exactly for the I-type rows (index 9..15).
    words[0]  = enc(7'h00, 3'b111, 7'h33); exp[0]  = {1'b1, ALU_AND};
    words[1]  = enc(7'h00, 3'b110, 7'h33); exp[1]  = {1'b1, ALU_OR};
    words[2]  = enc(7'h00, 3'b100, 7'h33); exp[2]  = {1'b1, ALU_XOR};
    words[3]  = enc(7'h00, 3'b010, 7'h33); exp[3]  = {1'b1, ALU_SLT};
    words[4]  = enc(7'h00, 3'b001, 7'h33); exp[4]  = {1'b1, ALU_SLL};
    words[5]  = enc(7'h00, 3'b101, 7'h33); exp[5]  = {1'b1, ALU_SRL};
    words[6]  = enc(7'h20, 3'b001, 7'h33); exp[6]  = 4'b0000;
    words[7]  = enc(7'h00, 3'b011, 7'h33); exp[7]  = 4'b0000;
    words[8]  = enc(7'h01, 3'b000, 7'h33); exp[8]  = 4'b0000;
    words[9]  = enc(7'h7f, 3'b111, 7'h13); exp[9]  = {1'b1, ALU_AND};
    words[10] = enc(7'h00, 3'b110, 7'h13); exp[10] = {1'b1, ALU_OR};
    words[11] = enc(7'h00, 3'b100, 7'h13); exp[11] = {1'b1, ALU_XOR};
    words[12] = enc(7'h00, 3'b010, 7'h13); exp[12] = {1'b1, ALU_SLT};
    words[13] = enc(7'h00, 3'b001, 7'h13); exp[13] = {1'b1, ALU_SLL};
    words[14] = enc(7'h00, 3'b101, 7'h13); exp[14] = {1'b1, ALU_SRL};
    words[15] = enc(7'h40, 3'b000, 7'h13); exp[15] = {1'b1, ALU_ADD};
    words[16] = enc(7'h20, 3'b101, 7'h13); exp[16] = 4'b0000;
    words[17] = enc(7'h00, 3'b011, 7'h13); exp[17] = 4'b0000;
    for (int k = 0; k < 18; k++) begin
      apply_reset(words[k], 1'b1);
      next_cycle();
      next_cycle();
      mid();
      if (exp[k][3]) begin
        checks++; if (state_out !== ST_EXECUTE) begin errors++; $display("FAIL decode_state row%0d: got %0d expected %0d", k, state_out, ST_EXECUTE); end
        checks++; if ({alu_op, use_imm} !== {exp[k][2:0], (k >= 9 && k <= 15)}) begin errors++; $display("FAIL decode_alu row%0d: got %b expected %b", k, {alu_op, use_imm}, {exp[k][2:0], (k >= 9 && k <= 15)}); end
      end else begin
        checks++; if (state_out !== ST_TRAP || trap !== 1'b1) begin errors++; $display("FAIL decode_trap row%0d: got state %0d trap %b expected %0d 1", k, state_out, trap, ST_TRAP); end
      end
    end
  endtask

  task automatic test_halt();
    int strobes;
    apply_reset(ADD_W, 1'b1);
    repeat (4) next_cycle();
    instruction = 32'd0;
    next_cycle();
    mid();
    checks++; if (state_out !== ST_DECODE) begin errors++; $display("FAIL halt_decode: got %0d expected %0d", state_out, ST_DECODE); end
    next_cycle();
    mid();
    checks++; if (state_out !== ST_HALT || halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got state %0d halted %b expected %0d 1", state_out, halted, ST_HALT); end
`ifdef PERF_COUNTERS_EN
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL halt_retired: got %0d expected 1", retired_count); end
`endif
    strobes = 0;
    instruction = ADD_W;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      mid();
      if (ir_write || pc_write || reg_write_enable) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL halt_quiet: got %0d strobe cycles expected 0", strobes); end
    checks++; if (halted !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL halt_sticky: got halted %b trap %b expected 1 0", halted, trap); end
  endtask

  task automatic test_trap();
    int writes;
    writes = 0;
    apply_reset(JAL_W, 1'b1);
    for (int i = 0; i < 12; i++) begin
      mid();
      if (reg_write_enable) writes++;
      next_cycle();
    end
    mid();
    checks++; if (state_out !== ST_TRAP || trap !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL trap_jal: got state %0d trap %b halted %b expected %0d 1 0", state_out, trap, halted, ST_TRAP); end
    checks++; if (writes !== 0) begin errors++; $display("FAIL trap_no_write: got %0d writes expected 0", writes); end
    apply_reset(SRLBAD_W, 1'b1);
    next_cycle();
    next_cycle();
    mid();
    checks++; if (state_out !== ST_TRAP || trap !== 1'b1) begin errors++; $display("FAIL trap_srl_f7: got state %0d trap %b expected %0d 1", state_out, trap, ST_TRAP); end
  endtask

  task automatic test_stall();
    int bad_state, bad_irw;
    bad_state = 0;
    bad_irw = 0;
    apply_reset(ADD_W, 1'b0);
    for (int i = 0; i < 5; i++) begin
      mid();
      if (state_out !== ST_FETCH) bad_state++;
      if (ir_write !== 1'b0) bad_irw++;
      next_cycle();
    end
    checks++; if (bad_state !== 0) begin errors++; $display("FAIL stall_state: got %0d bad cycles expected 0", bad_state); end
    checks++; if (bad_irw !== 0) begin errors++; $display("FAIL stall_ir_write: got %0d bad cycles expected 0", bad_irw); end
    run = 1'b1;
    mid();
    checks++; if (ir_write !== 1'b1) begin errors++; $display("FAIL stall_resume: got %b expected 1", ir_write); end
`ifdef PERF_COUNTERS_EN
    checks++; if (stall_count !== 32'd5) begin errors++; $display("FAIL stall_count: got %0d expected 5", stall_count); end
`endif
    repeat (3) next_cycle();
    mid();
    checks++; if (state_out !== ST_WRITEBACK || reg_write_enable !== 1'b1) begin errors++; $display("FAIL stall_complete: got state %0d rwe %b expected %0d 1", state_out, reg_write_enable, ST_WRITEBACK); end
  endtask

  task automatic test_max_retire();
    int extra;
    apply_reset(ADD_W, 1'b1);
    repeat (4) next_cycle();
    mid();
    checks++; if (lim_state !== ST_FETCH || lim_halted !== 1'b0) begin errors++; $display("FAIL maxret_first: got state %0d halted %b expected %0d 0", lim_state, lim_halted, ST_FETCH); end
    repeat (3) next_cycle();
    mid();
    checks++; if (lim_state !== ST_WRITEBACK || lim_rwe !== 1'b1) begin errors++; $display("FAIL maxret_second_wb: got state %0d rwe %b expected %0d 1", lim_state, lim_rwe, ST_WRITEBACK); end
    next_cycle();
    mid();
    checks++; if (lim_state !== ST_HALT || lim_halted !== 1'b1) begin errors++; $display("FAIL maxret_halt: got state %0d halted %b expected %0d 1", lim_state, lim_halted, ST_HALT); end
    checks++; if (state_out !== ST_FETCH || halted !== 1'b0) begin errors++; $display("FAIL maxret_unlimited: got state %0d halted %b expected %0d 0", state_out, halted, ST_FETCH); end
`ifdef PERF_COUNTERS_EN
    checks++; if (lim_retired_count !== 32'd2) begin errors++; $display("FAIL maxret_count: got %0d expected 2", lim_retired_count); end
`endif
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      mid();
      if (lim_rwe || lim_ir_write) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL maxret_third: got %0d strobe cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    apply_reset(ADD_W, 1'b1);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    mid();
    checks++; if (state_out !== ST_EXECUTE || reg_write_enable !== 1'b0) begin errors++; $display("FAIL rst_exec_cycle: got state %0d rwe %b expected %0d 0", state_out, reg_write_enable, ST_EXECUTE); end
    next_cycle();
    reset = 1'b0;
    mid();
    checks++; if (state_out !== ST_FETCH || reg_write_enable !== 1'b0) begin errors++; $display("FAIL rst_exec_after: got state %0d rwe %b expected %0d 0", state_out, reg_write_enable, ST_FETCH); end
    repeat (3) next_cycle();
    reset = 1'b1;
    mid();
    checks++; if (state_out !== ST_WRITEBACK || {reg_write_enable, pc_write} !== 2'b00) begin errors++; $display("FAIL rst_wb_gated: got state %0d strobes %b expected %0d 00", state_out, {reg_write_enable, pc_write}, ST_WRITEBACK); end
    next_cycle();
    reset = 1'b0;
    mid();
    checks++; if (state_out !== ST_FETCH) begin errors++; $display("FAIL rst_wb_after: got %0d expected %0d", state_out, ST_FETCH); end
`ifdef PERF_COUNTERS_EN
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL rst_wb_retired: got %0d expected 0", retired_count); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    instruction = 32'd0;
    test_reset();
    test_add();
    test_sub_addi();
    test_decode();
    test_halt();
    test_trap();
    test_stall();
    test_max_retire();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
